// File: rtl/nes_pkg.sv
// nes_pkg: shared opcode, state and register-index definitions
// Used by the NES loader RTL and mirrored in the host software headers.
package nes_pkg;

  typedef enum logic [7:0] {
    OP_RESET_CPU   = 8'd0,
    OP_START_CPU   = 8'd1,
    OP_START_WRITE = 8'd2,
    OP_WRITE       = 8'd3,
    OP_STOP_WRITE  = 8'd4,
    OP_HALT_CPU    = 8'd5,
    OP_START_READ  = 8'd6,
    OP_READ_NEXT   = 8'd7,
    OP_SELECT_BANK = 8'd8,
    OP_CLEAR_CSUM  = 8'd9
  } nes_op_t;

  typedef enum logic [1:0] {
    ST_HALT   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_RDWAIT = 2'd3
  } loader_state_t;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_PEND   = 2'd1;
  localparam logic [1:0] REG_RDBYTE = 2'd2;
  localparam logic [1:0] REG_CSUM   = 2'd3;

endpackage

// File: rtl/nes_loader.sv
// nes_loader: host command decoder, banked memory loader/reader
// and CPU run controller behind an Avalon-MM slave port.
module nes_loader
  import nes_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int NUM_BANKS = 2,
  parameter int MEM_DEPTH = 2**ADDR_W,
  localparam int BANK_W   =
    (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic              write,
  input  logic [15:0]       writedata,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  output logic [15:0]       readdata,
  output logic [BANK_W-1:0] mem_bank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              cpu_reset,
  output logic              cpu_ready
);

  loader_state_t     state_q, state_d;
  loader_state_t     ret_q, ret_d;
  logic              fetch_q, fetch_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        rdbyte_q, rdbyte_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              crst_q, crst_d;
  logic              crdy_q, crdy_d;

  nes_op_t           op;
  logic [7:0]        pl;
  logic              cmd;
  logic              busy;
  logic              mem_ok;
  logic [ADDR_W:0]   tgt_abs;
  logic [ADDR_W:0]   tgt_inc;

  assign op      = nes_op_t'(writedata[15:8]);
  assign pl      = writedata[7:0];
  assign cmd     = chipselect && write;
  assign busy    = fetch_q || (state_q == ST_RDWAIT);
  assign mem_ok  = (state_q == ST_HALT) ||
                   (state_q == ST_LOAD);
  assign tgt_abs = {1'b0, address};
  assign tgt_inc = {1'b0, addr_q} + (ADDR_W+1)'(1);

  // Address is out of range when past the bank or wrapped
  function automatic logic oob(input logic [ADDR_W:0] t);
    return t[ADDR_W] || (int'(t) >= MEM_DEPTH);
  endfunction

  // Next-state decode of host commands and read sequencing
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    fetch_d  = 1'b0;
    err_d    = err_q;
    pend_d   = pend_q;
    csum_d   = csum_q;
    rdbyte_d = rdbyte_q;
    bank_d   = bank_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    if (fetch_q) begin
      state_d = ST_RDWAIT;
    end
    if (state_q == ST_RDWAIT) begin
      rdbyte_d = mem_rdata;
      state_d  = ret_q;
    end
    if (cmd) begin
      if (busy) begin
        err_d = 1'b1;
      end else begin
        unique case (op)
          OP_RESET_CPU: begin
            state_d = ST_HALT;
            pend_d  = '0;
            err_d   = 1'b0;
          end
          OP_START_CPU: begin
            if (mem_ok) state_d = ST_RUN;
          end
          OP_START_WRITE: begin
            if (!mem_ok || oob(tgt_abs)) begin
              err_d = 1'b1;
            end else begin
              addr_d  = address;
              wdata_d = pl;
              we_d    = 1'b1;
              pend_d  = address + ADDR_W'(1);
              csum_d  = csum_q + pl;
              state_d = ST_LOAD;
            end
          end
          OP_WRITE: begin
            if (state_q != ST_LOAD || oob(tgt_inc)) begin
              err_d = 1'b1;
            end else begin
              addr_d  = tgt_inc[ADDR_W-1:0];
              wdata_d = pl;
              we_d    = 1'b1;
              pend_d  = pend_q + ADDR_W'(1);
              csum_d  = csum_q + pl;
            end
          end
          OP_STOP_WRITE: begin
            if (state_q == ST_LOAD) state_d = ST_HALT;
          end
          OP_HALT_CPU: begin
            if (state_q == ST_RUN) state_d = ST_HALT;
          end
          OP_START_READ: begin
            if (!mem_ok || oob(tgt_abs)) begin
              err_d = 1'b1;
            end else begin
              addr_d  = address;
              fetch_d = 1'b1;
              ret_d   = state_q;
            end
          end
          OP_READ_NEXT: begin
            if (!mem_ok || oob(tgt_inc)) begin
              err_d = 1'b1;
            end else begin
              addr_d  = tgt_inc[ADDR_W-1:0];
              fetch_d = 1'b1;
              ret_d   = state_q;
            end
          end
          OP_SELECT_BANK: begin
            if (!mem_ok || int'(pl) >= NUM_BANKS) begin
              err_d = 1'b1;
            end else begin
              bank_d = pl[BANK_W-1:0];
            end
          end
          OP_CLEAR_CSUM: begin
            if (!mem_ok) err_d = 1'b1;
            else         csum_d = '0;
          end
          default: err_d = 1'b1;
        endcase
      end
    end
    crst_d = (state_d != ST_RUN);
    crdy_d = (state_d == ST_RUN);
  end

  // Host register readback, sampled before this cycle's write
  always_comb begin
    rdata_d = rdata_q;
    if (chipselect && read) begin
      unique case (address[1:0])
        REG_STATUS: rdata_d = {8'b0, err_q, 3'b0,
                               state_q, busy, crdy_q};
        REG_PEND:   rdata_d = 16'(pend_q);
        REG_RDBYTE: rdata_d = {8'b0, rdbyte_q};
        REG_CSUM:   rdata_d = {8'b0, csum_q};
        default:    rdata_d = rdata_q;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_HALT;
      ret_q    <= ST_HALT;
      fetch_q  <= 1'b0;
      err_q    <= 1'b0;
      pend_q   <= '0;
      csum_q   <= '0;
      rdbyte_q <= '0;
      rdata_q  <= '0;
      bank_q   <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      crst_q   <= 1'b1;
      crdy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      fetch_q  <= fetch_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
      csum_q   <= csum_d;
      rdbyte_q <= rdbyte_d;
      rdata_q  <= rdata_d;
      bank_q   <= bank_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      crst_q   <= crst_d;
      crdy_q   <= crdy_d;
    end
  end

  assign readdata  = rdata_q;
  assign mem_bank  = bank_q;
  assign mem_addr  = addr_q;
  assign mem_write = we_q;
  assign mem_wdata = wdata_q;
  assign cpu_reset = crst_q;
  assign cpu_ready = crdy_q;

endmodule
